// File: rtl/sub_operand_loader.sv
// Bit-serial loader for the subtractor operands: shifts in A then B (LSB first)
// and presents the pair, held stable, under a valid/ready handshake.
module sub_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             busy,
    output logic             err
);

    // state   | meaning
    // IDLE    | waiting for start
    // LOAD_A  | shifting in minuend bits
    // LOAD_B  | shifting in subtrahend bits
    // PRESENT | pair on a_out/b_out, waiting for op_ready
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD_A  = 2'd1;
    localparam logic [1:0] LOAD_B  = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic             loading;
    logic             accept;
    logic             last_bit;
    logic             enter_a;
    logic             enter_b;

    assign loading  = (state == LOAD_A) || (state == LOAD_B);
    // start while loading aborts, so that cycle's bit is never taken
    assign accept   = loading && ser_valid && !start;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_A;
            end
            LOAD_A: begin
                if (start)                   state_nxt = LOAD_A;
                else if (accept && last_bit) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                if (start)                   state_nxt = LOAD_A;
                else if (accept && last_bit) state_nxt = PRESENT;
            end
            PRESENT: begin
                if (op_ready) state_nxt = start ? LOAD_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_a = (state_nxt == LOAD_A) && ((state != LOAD_A) || start);
    assign enter_b = (state_nxt == LOAD_B) && (state != LOAD_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sr_a     <= '0;
            sr_b     <= '0;
            a_out    <= '0;
            b_out    <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            op_valid <= (state_nxt == PRESENT);
            err      <= start && loading;

            if (enter_a || enter_b) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end

            if (enter_a) begin
                sr_a <= '0;
                sr_b <= '0;
            end else if (accept && (state == LOAD_A)) begin
                sr_a <= {ser_in, sr_a[WIDTH-1:1]};
            end else if (accept && (state == LOAD_B)) begin
                sr_b <= {ser_in, sr_b[WIDTH-1:1]};
            end

            // outputs only change on the way into PRESENT
            if ((state == LOAD_B) && (state_nxt == PRESENT)) begin
                a_out <= sr_a;
                b_out <= {ser_in, sr_b[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_sub_operand_loader.sv
// Directed bench for sub_operand_loader: load/present, stall, gaps, abort,
// reset mid-operation and simultaneous start events.
module tb_sub_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    sub_operand_loader #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends a frame LSB first; with gapped set, every data bit is preceded by
    // an idle cycle. Checks that the previous pair is held up to the last bit.
    task automatic frame(input bit do_start, input logic [7:0] a, input logic [7:0] b,
                         input bit gapped, input logic [7:0] hold_a, input logic [7:0] hold_b);
        logic bv;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("busy_load", busy, 1);
        for (int i = 0; i < 16; i++) begin
            bv = (i < 8) ? a[i] : b[i-8];
            if (gapped) begin
                ser_valid = 1'b0;
                tick();
            end
            if (i == 15) begin
                chk("valid_early", op_valid, 0);
                chk("hold_a", a_out, hold_a);
                chk("hold_b", b_out, hold_b);
            end
            ser_valid = 1'b1;
            ser_in    = bv;
            tick();
        end
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ser_valid = 1'b1;
            ser_in    = w[i];
            tick();
        end
        ser_valid = 1'b0;
    endtask

    initial begin
        // reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        // basic load, op_valid at cycle 17 for one cycle
        op_ready = 1'b1;
        frame(1'b1, 8'h55, 8'hEB, 1'b0, 8'h00, 8'h00);
        chk("basic_valid", op_valid, 1);
        chk("basic_a", a_out, 8'h55);
        chk("basic_b", b_out, 8'hEB);
        chk("basic_diff", 8'(a_out - b_out), 8'h6A);
        tick();
        chk("basic_valid_drop", op_valid, 0);
        chk("basic_idle", busy, 0);
        chk("basic_a_hold", a_out, 8'h55);

        // second frame with a 5-cycle stall; ser_valid and start in PRESENT ignored
        op_ready = 1'b0;
        frame(1'b1, 8'h58, 8'hF7, 1'b0, 8'h55, 8'hEB);
        chk("stall_valid", op_valid, 1);
        chk("stall_a", a_out, 8'h58);
        chk("stall_b", b_out, 8'hF7);
        for (int i = 0; i < 5; i++) begin
            ser_valid = 1'b1;
            ser_in    = 1'b1;
            start     = (i == 2);
            tick();
            chk("stall_hold_valid", op_valid, 1);
            chk("stall_hold_a", a_out, 8'h58);
            chk("stall_hold_b", b_out, 8'hF7);
            chk("stall_no_err", err, 0);
        end
        start     = 1'b0;
        ser_valid = 1'b0;
        op_ready  = 1'b1;
        tick();
        chk("stall_done_valid", op_valid, 0);
        chk("stall_done_busy", busy, 0);

        // gapped input, op_valid at cycle 33
        frame(1'b1, 8'h55, 8'hEB, 1'b1, 8'h58, 8'hF7);
        chk("gap_valid", op_valid, 1);
        chk("gap_a", a_out, 8'h55);
        chk("gap_b", b_out, 8'hEB);

        // start together with op_ready in PRESENT: straight into LOAD_A
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_valid_drop", op_valid, 0);
        chk("b2b_busy", busy, 1);
        frame(1'b0, 8'hA3, 8'h3C, 1'b0, 8'h55, 8'hEB);
        chk("b2b_a", a_out, 8'hA3);
        chk("b2b_b", b_out, 8'h3C);
        tick();

        // abort after 5 A bits, then full reload
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(8'hFF, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_a_hold", a_out, 8'hA3);
        tick();
        chk("abort_err_clear", err, 0);
        frame(1'b0, 8'h58, 8'hF7, 1'b0, 8'hA3, 8'h3C);
        chk("abort_valid", op_valid, 1);
        chk("abort_a", a_out, 8'h58);
        chk("abort_b", b_out, 8'hF7);
        tick();

        // start with ser_valid in IDLE: that bit must not be captured
        start     = 1'b1;
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        tick();
        start = 1'b0;
        frame(1'b0, 8'h5A, 8'hC3, 1'b0, 8'h58, 8'hF7);
        chk("simul_valid", op_valid, 1);
        chk("simul_a", a_out, 8'h5A);
        chk("simul_b", b_out, 8'hC3);
        tick();

        // reset during LOAD_B
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(8'h96, 8);
        send_bits(8'h0F, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstb_a", a_out, 0);
        chk("rstb_b", b_out, 0);
        chk("rstb_valid", op_valid, 0);
        chk("rstb_busy", busy, 0);

        // reset during PRESENT, then ser_valid pulses are ignored
        op_ready = 1'b0;
        frame(1'b1, 8'h55, 8'hEB, 1'b0, 8'h00, 8'h00);
        chk("rstp_pre_valid", op_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstp_valid", op_valid, 0);
        chk("rstp_a", a_out, 0);
        op_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ser_valid = i[0];
            ser_in    = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
        chk("rstp_idle_busy", busy, 0);
        chk("rstp_idle_valid", op_valid, 0);
        chk("rstp_idle_a", a_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_operand_loader.md
# sub_operand_loader

Bit-serial operand loader that sits directly upstream of the 8-bit subtractor. It assembles the minuend `a` and subtrahend `b` from a single serial data line, LSB first, and presents both words in parallel, held stable, under a valid/ready handshake. The subtractor's inputs never change while an operand pair is being offered.

## Interface
- `WIDTH`, default 8: operand width in bits. This is also the number of serial bits per operand.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: begins a new operand frame.
- `ser_in`  in  1: serial data bit.
- `ser_valid`  in  1: `ser_in` is valid this cycle.
- `a_out`  out  WIDTH: assembled minuend; drives subtractor `a`.
- `b_out`  out  WIDTH: assembled subtrahend; drives subtractor `b`.
- `op_valid`  out  1: `a_out`/`b_out` hold a complete pair.
- `op_ready`  in  1: downstream accepts the pair.
- `busy`  out  1: high whenever state is not IDLE.
- `err`  out  1: one-cycle pulse when a frame is aborted by `start`.

## Operation
- States and transitions:
  - IDLE → LOAD_A on `start`.
  - LOAD_A → LOAD_B after WIDTH accepted bits.
  - LOAD_B → PRESENT after WIDTH accepted bits.
  - PRESENT → IDLE on `op_valid && op_ready`.
- Accepted bit: `ser_valid` high while in LOAD_A or LOAD_B. Only accepted bits are counted.
- `ser_valid` is ignored in IDLE and PRESENT.
- Bit ordering: the k-th accepted bit (k = 0..WIDTH-1) of each operand becomes bit k of that operand (LSB first).
- Shift-register realisation: shift right, new bit enters at the MSB. After WIDTH bits the word is in correct order.
- Bit counter: width ceil(log2(WIDTH)). Cleared on entry to LOAD_A and to LOAD_B. Wraps only through these clears, never by overflow.
- Shadow registers: the A and B shift registers are internal. `a_out`/`b_out` load from them only on the transition into PRESENT, and otherwise hold their last values, including through IDLE and loading.
- `start` during LOAD_A or LOAD_B:
  - aborts the frame and restarts in LOAD_A with the counter cleared;
  - discards partial data;
  - `err` is 1 in the following cycle only;
  - `a_out`/`b_out` are unchanged.
- `start` in PRESENT:
  - without `op_ready`: ignored; no error.
  - with `op_ready` in the same cycle: the handshake completes and the next state is LOAD_A, not IDLE.
- `start` and `ser_valid` in the same IDLE cycle: `ser_in` is not captured. The first data bit is taken no earlier than the cycle after `start`.
- No arithmetic is performed in this block. Values are raw bit patterns; signedness is the subtractor's concern.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Reset (`rst` = 1 at a clock edge) produces:
  - state IDLE, counter 0;
  - `a_out` = 0, `b_out` = 0;
  - `op_valid` = 0, `busy` = 0, `err` = 0;
  - internal shift registers = 0.
- Reset takes priority over every other input, including mid-frame and during PRESENT. A held pair is dropped without handshake.
- Latency: with `start` at cycle 0 and `ser_valid` high continuously from cycle 1, the bits land in cycles 1..2·WIDTH. `op_valid` rises at cycle 2·WIDTH+1 (17 for WIDTH = 8). Each `ser_valid` gap adds one cycle.
- While in PRESENT: `op_valid` stays high, and `a_out`/`b_out` stay constant, until the handshake cycle.
- `op_valid` drops in the cycle after the handshake.
- `busy` rises the cycle after `start`, and falls the cycle after the handshake unless a back-to-back `start` occurred.
- Throughput: one pair per 2·WIDTH+1 cycles, using back-to-back `start` with `op_ready` tied high.

## Test plan
- Basic load: `start`, then serial A bits 1,0,1,0,1,0,1,0 and B bits 1,1,0,1,0,1,1,1, `op_ready` = 1 → `a_out` = 0x55, `b_out` = 0xEB, `op_valid` high at cycle 17 for exactly one cycle; subtractor result 0x6A.
- Back-to-back with stall:
  - Second frame: A bits 0,0,0,1,1,0,1,0 and B bits 1,1,1,0,1,1,1,1; `op_ready` low for 5 cycles → `a_out` = 0x58, `b_out` = 0xF7 held constant, `op_valid` high through the stall.
  - First pair 0x55/0xEB remains on the outputs throughout the second load.
- Gapped input: `ser_valid` toggling every other cycle → same 0x55/0xEB pair; `op_valid` at cycle 33.
- Abort:
  - `start` after 5 A bits → `err` pulses for 1 cycle and the counter restarts.
  - Full reload of 0x58/0xF7 → exactly that pair is presented; no residue from the aborted frame.
- Reset mid-operation:
  - `rst` during LOAD_B → all outputs 0 the next cycle, `busy` = 0.
  - `rst` during PRESENT → `op_valid` = 0 the next cycle; `ser_valid` pulses afterwards are ignored until `start`.
- Simultaneous events:
  - `start` with `op_ready` in PRESENT → next state LOAD_A, `busy` stays 1.
  - `start` with `ser_valid` = 1 in IDLE → that bit is not captured.
